// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte widths, sequencer state encoding and the
// inverse S-box table with its lookup function.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Row r, column c holds InvSBox[16*r + c].
  localparam logic [AES_BYTE_W-1:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [AES_BYTE_W-1:0] inv_sbox_f(input logic [AES_BYTE_W-1:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready input and output channels of the InvSubBytes sequencer; bytes are
// numbered from bit 0 upward, byte k occupying bits [8k:8k+7].
interface inv_sub_bytes_seq_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [0:AES_STATE_W-1] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [0:AES_STATE_W-1] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/inv_sub_bytes_seq_inv_sbox.sv
// Single combinational inverse S-box byte lookup; the sequencer instantiates one
// per lane.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] byte_i,
  output logic [AES_BYTE_W-1:0] byte_o
);

  assign byte_o = inv_sbox_f(byte_i);

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Time-multiplexed InvSubBytes: LANES shared inverse S-box lookups sweep the
// 16-byte state in place over 16/LANES passes, behind valid/ready handshakes.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  output logic               busy,
  inv_sub_bytes_seq_if.slave bus
);

  localparam int PASSES = 16 / LANES;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_BUSY = 2'(BUSY);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   drain_q, drain_d;
  logic [0:AES_STATE_W-1] data_q, data_d;

  logic [3:0]            lane_sel [LANES];
  logic [AES_BYTE_W-1:0] lane_in  [LANES];
  logic [AES_BYTE_W-1:0] lane_out [LANES];

  logic accept;
  logic last_pass;

  // Lane l of pass p works on byte p*LANES + l.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_sel[l] = 4'(int'(cnt_q) * LANES + l);
    assign lane_in[l]  = data_q[{lane_sel[l], 3'b000} +: AES_BYTE_W];

    inv_sbox u_sbox (
      .byte_i (lane_in[l]),
      .byte_o (lane_out[l])
    );
  end

  assign bus.in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = data_q;
  assign busy          = (state_q == ST_BUSY);

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_pass = (cnt_q == CNT_W'(PASSES - 1));

  // After the final write-back one settling cycle (drain) is spent in BUSY
  // before the result is offered, so out_valid rises PASSES+1 edges after accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    data_d  = data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = bus.in_data;
          cnt_d   = '0;
          drain_d = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          for (int l = 0; l < LANES; l++) begin
            data_d[{lane_sel[l], 3'b000} +: AES_BYTE_W] = lane_out[l];
          end
          if (last_pass) begin
            cnt_d   = '0;
            drain_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (accept) begin
          data_d  = bus.in_data;
          cnt_d   = '0;
          drain_d = 1'b0;
          state_d = ST_BUSY;
        end else if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over any handshake; the held state is deliberately kept.
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      drain_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      data_q  <= data_d;
    end
  end

endmodule
